// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch stage: datapath widths,
// the NOP encoding and the fetch FSM state type.
package fetch_unit_pkg;

  localparam int CPU_PC_W  = 8;
  localparam int CPU_INS_W = 16;

  localparam logic [CPU_INS_W-1:0] NOP_INS = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the PC, fetches one instruction at a time from
// instruction memory and feeds the IF/ID register, honouring stalls and redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = CPU_PC_W,
  parameter int              INS_W    = CPU_INS_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [INS_W-1:0] ins_o,
  output logic             ins_valid,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  link_pc,
  output fetch_state_e     state_dbg
);

  // imem handshake: imem_req rises in REQ and stays high through WAIT with
  // imem_addr stable; the single outstanding request completes on the first
  // cycle with imem_ack=1. A squashed request is drained with imem_req low, so
  // the fetch for the redirect target never overlaps it.

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             squash_q, squash_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_o_q, pc_o_d;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    ins_d    = INS_W'(NOP_INS);
    valid_d  = 1'b0;
    pc_o_d   = pc_o_q;
    imem_req = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (squash_q) begin
          if (imem_ack) squash_d = 1'b0;
        end else if (!stall && !redirect_valid) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (imem_ack && !redirect_valid) begin
          ins_d   = imem_rdata;
          valid_d = 1'b1;
          pc_o_d  = pc_q;
          pc_d    = pc_q + PC_W'(1);
          state_d = stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (stall) begin
          ins_d   = ins_q;
          valid_d = valid_q;
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides stall and any ack arriving in the same cycle.
    if (redirect_valid && state_q != IDLE) begin
      pc_d    = redirect_pc;
      state_d = REQ;
      ins_d   = INS_W'(NOP_INS);
      valid_d = 1'b0;
      if (state_q == WAIT && !imem_ack) squash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      ins_q    <= INS_W'(NOP_INS);
      valid_q  <= 1'b0;
      pc_o_q   <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      ins_q    <= ins_d;
      valid_q  <= valid_d;
      pc_o_q   <= pc_o_d;
    end
  end

  assign imem_addr = pc_q;
  assign ins_o     = ins_q;
  assign ins_valid = valid_q;
  assign pc_o      = pc_o_q;
  assign link_pc   = pc_o_q + PC_W'(1);
  assign state_dbg = state_q;

endmodule
